// File: rtl/count_seq_monitor.sv
// Receiver-side checker for a wrapping up-counter stream: tracks the expected
// next value, flags mismatches / out-of-range samples and keeps error/wrap stats.
module count_seq_monitor #(
  parameter int WIDTH      = 4,
  parameter int MAX_VAL    = 15,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  resync_i,
  input  logic                  clr_i,
  output logic                  locked_o,
  output logic [WIDTH-1:0]      exp_o,
  output logic                  err_pulse_o,
  output logic                  range_err_o,
  output logic                  err_sticky_o,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic [WIDTH-1:0]      first_bad_o,
  output logic [WIDTH-1:0]      first_exp_o,
  output logic [WRAP_CNT_W-1:0] wrap_count_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        exp_q, exp_d;
  logic                    prev_max_q, prev_max_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    range_err_q, range_err_d;
  logic                    sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d, err_base;
  logic [WRAP_CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d, wrap_base;
  logic [WIDTH-1:0]        first_bad_q, first_bad_d;
  logic [WIDTH-1:0]        first_exp_q, first_exp_d;

  logic             sample, over, mism, range_hit, err, wrap;
  logic [WIDTH-1:0] succ;

  // Resync takes priority: a sample in the same cycle is not checked at all.
  assign sample    = valid_i && !resync_i;
  assign over      = count_i > MAX_W;
  assign succ      = (count_i == MAX_W) ? '0 : count_i + WIDTH'(1);
  assign mism      = sample && (state_q == LOCKED) && (count_i != exp_q);
  assign range_hit = sample && over;
  assign err       = mism || range_hit;
  assign wrap      = sample && (state_q == LOCKED) && !mism &&
                     (count_i == '0) && prev_max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      exp_q       <= '0;
      prev_max_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      range_err_q <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      first_bad_q <= '0;
      first_exp_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      prev_max_q  <= prev_max_d;
      err_pulse_q <= err_pulse_d;
      range_err_q <= range_err_d;
      sticky_q    <= sticky_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      first_bad_q <= first_bad_d;
      first_exp_q <= first_exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (resync_i)     state_d = UNLOCKED;
    else if (valid_i) state_d = over ? UNLOCKED : LOCKED;
  end

  // Clear is applied first so that an error or wrap in the same cycle lands on top of it.
  always_comb begin
    exp_d       = exp_q;
    prev_max_d  = prev_max_q;
    err_pulse_d = mism;
    range_err_d = range_hit;
    err_base    = clr_i ? '0 : err_cnt_q;
    wrap_base   = clr_i ? '0 : wrap_cnt_q;
    sticky_d    = clr_i ? 1'b0 : sticky_q;
    first_bad_d = clr_i ? '0 : first_bad_q;
    first_exp_d = clr_i ? '0 : first_exp_q;
    err_cnt_d   = err_base;
    wrap_cnt_d  = wrap_base;
    if (resync_i) begin
      exp_d      = '0;
      prev_max_d = 1'b0;
    end else if (valid_i) begin
      exp_d      = succ;
      prev_max_d = (count_i == MAX_W);
    end
    if (err) begin
      sticky_d = 1'b1;
      if (err_base != '1) err_cnt_d = err_base + ERR_CNT_W'(1);
      if (!sticky_q || clr_i) begin
        first_bad_d = count_i;
        first_exp_d = (state_q == LOCKED) ? exp_q : '0;
      end
    end
    if (wrap && wrap_base != '1) wrap_cnt_d = wrap_base + WRAP_CNT_W'(1);
  end

  always_comb begin
    locked_o     = (state_q == LOCKED);
    exp_o        = exp_q;
    err_pulse_o  = err_pulse_q;
    range_err_o  = range_err_q;
    err_sticky_o = sticky_q;
    err_count_o  = err_cnt_q;
    first_bad_o  = first_bad_q;
    first_exp_o  = first_exp_q;
    wrap_count_o = wrap_cnt_q;
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: default instance (MAX_VAL=15) plus a
// MAX_VAL=9 instance for the out-of-range path.
module tb_count_seq_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v = 1'b0, rs = 1'b0, cl = 1'b0;
  logic [3:0] c = '0;
  logic       lk, ep, re, st;
  logic [3:0] ex, fb, fe;
  logic [7:0] ec, wc;

  logic       v9 = 1'b0, rs9 = 1'b0, cl9 = 1'b0;
  logic [3:0] c9 = '0;
  logic       lk9, ep9, re9, st9;
  logic [3:0] ex9, fb9, fe9;
  logic [7:0] ec9, wc9;

  int n_chk = 0;
  int n_err = 0;

  count_seq_monitor dut (
    .clk(clk), .rst(rst), .valid_i(v), .count_i(c), .resync_i(rs), .clr_i(cl),
    .locked_o(lk), .exp_o(ex), .err_pulse_o(ep), .range_err_o(re),
    .err_sticky_o(st), .err_count_o(ec), .first_bad_o(fb), .first_exp_o(fe),
    .wrap_count_o(wc));

  count_seq_monitor #(.MAX_VAL(9)) dut9 (
    .clk(clk), .rst(rst), .valid_i(v9), .count_i(c9), .resync_i(rs9), .clr_i(cl9),
    .locked_o(lk9), .exp_o(ex9), .err_pulse_o(ep9), .range_err_o(re9),
    .err_sticky_o(st9), .err_count_o(ec9), .first_bad_o(fb9), .first_exp_o(fe9),
    .wrap_count_o(wc9));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Drive one cycle on the default instance; outputs are checked 1ns after the edge.
  task automatic cyc(input logic val, input logic [3:0] cnt, input logic rsy, input logic clr);
    @(negedge clk); v = val; c = cnt; rs = rsy; cl = clr;
    @(posedge clk); #1; v = 1'b0; rs = 1'b0; cl = 1'b0;
  endtask

  task automatic smp(input logic [3:0] cnt);
    cyc(1'b1, cnt, 1'b0, 1'b0);
  endtask

  task automatic smp9(input logic [3:0] cnt);
    @(negedge clk); v9 = 1'b1; c9 = cnt;
    @(posedge clk); #1; v9 = 1'b0;
  endtask

  initial begin
    do_rst();
    #1;
    chk("rst_locked", 32'(lk), 0);
    chk("rst_exp", 32'(ex), 0);
    chk("rst_errcnt", 32'(ec), 0);
    chk("rst_sticky", 32'(st), 0);
    chk("rst_wrap", 32'(wc), 0);
    chk("rst_first_bad", 32'(fb), 0);

    // Clean count 0..15,0,1
    smp(4'd0);
    chk("lock_after_first", 32'(lk), 1);
    chk("exp_after_first", 32'(ex), 1);
    for (int i = 1; i < 16; i++) smp(4'(i));
    smp(4'd0);
    smp(4'd1);
    chk("clean_errcnt", 32'(ec), 0);
    chk("clean_wrap", 32'(wc), 1);
    chk("clean_exp", 32'(ex), 2);
    chk("clean_pulse", 32'(ep), 0);
    // Wrap in the same cycle as clr: counter restarts at 1
    for (int i = 2; i < 16; i++) smp(4'(i));
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    chk("wrap_clr", 32'(wc), 1);

    // 14-wrap bug
    do_rst();
    smp(4'd12); smp(4'd13); smp(4'd14); smp(4'd0);
    chk("wrap14_pulse", 32'(ep), 1);
    chk("wrap14_bad", 32'(fb), 0);
    chk("wrap14_exp", 32'(fe), 15);
    chk("wrap14_cnt", 32'(ec), 1);
    chk("wrap14_nxt", 32'(ex), 1);
    chk("wrap14_wrapcnt", 32'(wc), 0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("pulse_clears", 32'(ep), 0);
    chk("sticky_holds", 32'(st), 1);

    // Two errors, first pair captured
    do_rst();
    smp(4'd3); smp(4'd5); smp(4'd6); smp(4'd9);
    chk("two_cnt", 32'(ec), 2);
    chk("two_bad", 32'(fb), 5);
    chk("two_exp", 32'(fe), 4);
    chk("two_sticky", 32'(st), 1);
    chk("two_nxt", 32'(ex), 10);
    chk("two_locked", 32'(lk), 1);

    // MAX_VAL=9: out-of-range while unlocked
    do_rst();
    smp9(4'd12);
    chk("rng_flag", 32'(re9), 1);
    chk("rng_locked", 32'(lk9), 0);
    chk("rng_cnt", 32'(ec9), 1);
    chk("rng_bad", 32'(fb9), 12);
    chk("rng_exp", 32'(fe9), 0);
    smp9(4'd4);
    chk("rng_relock", 32'(lk9), 1);
    chk("rng_relock_exp", 32'(ex9), 5);
    chk("rng_flag_clr", 32'(re9), 0);

    // Error counter saturation, then clear-with-error and plain clear
    do_rst();
    smp(4'd0);
    for (int i = 0; i < 300; i++) smp(4'd5);
    chk("sat_cnt", 32'(ec), 255);
    chk("sat_bad", 32'(fb), 5);
    chk("sat_exp", 32'(fe), 1);
    cyc(1'b1, 4'd9, 1'b0, 1'b1);
    chk("clr_err_cnt", 32'(ec), 1);
    chk("clr_err_sticky", 32'(st), 1);
    chk("clr_err_bad", 32'(fb), 9);
    chk("clr_err_exp", 32'(fe), 6);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("clr_cnt", 32'(ec), 0);
    chk("clr_sticky", 32'(st), 0);
    chk("clr_bad", 32'(fb), 0);

    // Resync suppresses checking; rst discards everything
    do_rst();
    smp(4'd6);
    chk("rs_pre_exp", 32'(ex), 7);
    cyc(1'b1, 4'd0, 1'b1, 1'b0);
    chk("rs_locked", 32'(lk), 0);
    chk("rs_exp", 32'(ex), 0);
    chk("rs_pulse", 32'(ep), 0);
    chk("rs_cnt", 32'(ec), 0);
    smp(4'd0);
    chk("rs_relock", 32'(lk), 1);
    chk("rs_relock_exp", 32'(ex), 1);
    smp(4'd6);
    chk("pre_rst_cnt", 32'(ec), 1);
    chk("pre_rst_exp", 32'(ex), 7);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_locked", 32'(lk), 0);
    chk("midrst_exp", 32'(ex), 0);
    chk("midrst_cnt", 32'(ec), 0);
    chk("midrst_sticky", 32'(st), 0);
    chk("midrst_bad", 32'(fb), 0);
    chk("midrst_fexp", 32'(fe), 0);
    chk("midrst_pulse", 32'(ep), 0);
    @(negedge clk); rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
